// File: rtl/outp_frame_collector.sv
// outp_frame_collector
// Samples the comparator's serial result (outp) and overflow flag (overflw)
// on a strobe and packs FRAME_W samples into a parallel word. Each word is
// presented through a single-entry valid/ready buffer together with a
// per-frame overflow flag. A saturating counter tracks overflow samples.
//
// Optional feature: define OUTP_FRAME_COLLECTOR_PARITY_EN to register the
// XOR-reduction of each completed word on frame_parity. When it is not
// defined, frame_parity is tied to 0.
//
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   sample_en      - sampling strobe for bit_in / ovf_in
//   bit_in         - serial data (comparator outp)
//   ovf_in         - overflow flag (comparator overflw)
//   frame_ready    - consumer accepts the buffered word
//   frame_valid    - buffer holds a complete frame
//   frame_data     - completed frame, first sampled bit in the MSB
//   frame_ovf      - ovf_in was seen on at least one sample of the frame
//   frame_parity   - XOR of frame_data (0 when parity is not built)
//   ovf_count      - saturating count of samples with ovf_in=1
//   drop_err       - one-cycle pulse when a completed frame is discarded
module outp_frame_collector #(
    parameter int unsigned FRAME_W   = 8,
    parameter int unsigned OVF_CNT_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic                 bit_in,
    input  logic                 ovf_in,
    input  logic                 frame_ready,
    output logic                 frame_valid,
    output logic [FRAME_W-1:0]   frame_data,
    output logic                 frame_ovf,
    output logic                 frame_parity,
    output logic [OVF_CNT_W-1:0] ovf_count,
    output logic                 drop_err
);

    localparam int unsigned CNT_W = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [FRAME_W-2:0] sreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               frame_ovf_acc;

    logic               complete_c;
    logic               load_c;
    logic               drop_c;
    logic [FRAME_W-1:0] word_c;
    logic               word_ovf_c;

    // Assembled word and overflow status including the current sample
    assign word_c     = {sreg, bit_in};
    assign word_ovf_c = frame_ovf_acc | ovf_in;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, completion detect and buffer load/drop decision
    always_comb begin
        state_next = state;
        complete_c = 1'b0;
        load_c     = 1'b0;
        drop_c     = 1'b0;
        case (state)
            IDLE: begin
                if (sample_en) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (sample_en && (bit_cnt == CNT_LAST)) begin
                    complete_c = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A draining buffer can take the new word in the same cycle
        if (complete_c) begin
            if (!frame_valid || frame_ready) begin
                load_c = 1'b1;
            end else begin
                drop_c = 1'b1;
            end
        end
    end

    // Collection datapath, output buffer and overflow counter
    always_ff @(posedge clock) begin
        if (reset) begin
            sreg          <= '0;
            bit_cnt       <= '0;
            frame_ovf_acc <= 1'b0;
            ovf_count     <= '0;
            drop_err      <= 1'b0;
            frame_valid   <= 1'b0;
            frame_data    <= '0;
            frame_ovf     <= 1'b0;
        end else begin
            if (sample_en) begin
                sreg          <= word_c[FRAME_W-2:0];
                bit_cnt       <= complete_c ? '0 : bit_cnt + CNT_W'(1);
                frame_ovf_acc <= complete_c ? 1'b0 : word_ovf_c;
                if (ovf_in && (ovf_count != '1)) begin
                    ovf_count <= ovf_count + OVF_CNT_W'(1);
                end
            end
            drop_err <= drop_c;
            if (load_c) begin
                frame_valid <= 1'b1;
                frame_data  <= word_c;
                frame_ovf   <= word_ovf_c;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

`ifdef OUTP_FRAME_COLLECTOR_PARITY_EN
    logic par_acc;

    // Running parity of the partial frame, folded into the buffer on load
    always_ff @(posedge clock) begin
        if (reset) begin
            par_acc      <= 1'b0;
            frame_parity <= 1'b0;
        end else begin
            if (sample_en) begin
                par_acc <= complete_c ? 1'b0 : (par_acc ^ bit_in);
            end
            if (load_c) begin
                frame_parity <= par_acc ^ bit_in;
            end
        end
    end
`else
    assign frame_parity = 1'b0;
`endif

endmodule

// File: tb/tb_outp_frame_collector.sv
// Self-checking bench for outp_frame_collector: a vector table for the basic
// frames, hand sequences for drop / back-to-back / saturation / reset, and a
// randomized phase compared against a queue-based reference model.
module tb_outp_frame_collector;

    localparam int unsigned FW      = 8;
    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          sample_en;
    logic          bit_in;
    logic          ovf_in;
    logic          frame_ready;
    logic          frame_valid;
    logic [FW-1:0] frame_data;
    logic          frame_ovf;
    logic          frame_parity;
    logic [CW-1:0] ovf_count;
    logic          drop_err;

    int errors = 0;
    int checks = 0;

    outp_frame_collector #(
        .FRAME_W   (FW),
        .OVF_CNT_W (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_en    (sample_en),
        .bit_in       (bit_in),
        .ovf_in       (ovf_in),
        .frame_ready  (frame_ready),
        .frame_valid  (frame_valid),
        .frame_data   (frame_data),
        .frame_ovf    (frame_ovf),
        .frame_parity (frame_parity),
        .ovf_count    (ovf_count),
        .drop_err     (drop_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          se;
        logic          b;
        logic          o;
        logic          r;
        logic          v;
        logic [FW-1:0] d;
        logic          fo;
        logic          dr;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tv[18];

    function automatic logic par_of(input logic [FW-1:0] d);
`ifdef OUTP_FRAME_COLLECTOR_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        sample_en = 1'b0;
        bit_in    = 1'b0;
        ovf_in    = 1'b0;
    endtask

    // Sends one frame MSB first; ovf mask bit i goes with data bit i
    task automatic send(input logic [FW-1:0] w, input logic [FW-1:0] om);
        for (int i = int'(FW) - 1; i >= 0; i--) begin
            sample_en = 1'b1;
            bit_in    = w[i];
            ovf_in    = om[i];
            tick();
        end
        idle_inputs();
    endtask

    // Reference model state
    logic          m_valid;
    logic [FW-1:0] m_data;
    logic          m_ovf;
    logic          m_par;
    logic          m_drop;
    int            m_cnt;
    int            q_bits[$];
    logic          q_ovf;

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_par   = 1'b0;
        m_drop  = 1'b0;
        m_cnt   = 0;
        q_bits.delete();
        q_ovf   = 1'b0;
    endtask

    task automatic model_step(input logic rst, input logic se, input logic b,
                              input logic o, input logic rdy);
        logic xfer;
        logic loaded;
        int   wint;
        if (rst) begin
            model_reset();
            return;
        end
        xfer   = m_valid && rdy;
        loaded = 1'b0;
        m_drop = 1'b0;
        if (se) begin
            q_bits.push_back(int'(b));
            q_ovf = q_ovf | o;
            if (o && m_cnt < CNT_MAX) m_cnt++;
            if (q_bits.size() == int'(FW)) begin
                wint = 0;
                foreach (q_bits[j]) wint = wint * 2 + q_bits[j];
                if (!m_valid || rdy) begin
                    m_valid = 1'b1;
                    m_data  = FW'(wint);
                    m_ovf   = q_ovf;
                    m_par   = par_of(FW'(wint));
                    loaded  = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
                q_bits.delete();
                q_ovf = 1'b0;
            end
        end
        if (xfer && !loaded) m_valid = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] pat;
        logic [15:0]   sat_bits;

        // Table: frame 0xB2 without overflow, then with overflow on samples 3 and 8
        pat = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            tv[i] = '{se: 1'b1, b: pat[7-i], o: 1'b0, r: 1'b1, v: (i == 7),
                      d: (i == 7) ? 8'hB2 : 8'h00, fo: 1'b0, dr: 1'b0, cnt: CW'(0)};
        end
        tv[8] = '{se: 1'b0, b: 1'b0, o: 1'b0, r: 1'b1, v: 1'b0, d: 8'hB2,
                  fo: 1'b0, dr: 1'b0, cnt: CW'(0)};
        for (int i = 0; i < 8; i++) begin
            tv[9+i] = '{se: 1'b1, b: pat[7-i], o: (i == 2 || i == 7), r: 1'b1,
                        v: (i == 7), d: 8'hB2, fo: (i == 7), dr: 1'b0,
                        cnt: (i < 2) ? CW'(0) : ((i < 7) ? CW'(1) : CW'(2))};
        end
        tv[17] = '{se: 1'b0, b: 1'b0, o: 1'b0, r: 1'b1, v: 1'b0, d: 8'hB2,
                   fo: 1'b1, dr: 1'b0, cnt: CW'(2)};

        // Reset state
        reset = 1'b1;
        frame_ready = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        chk("rst.valid", frame_valid, 0);
        chk("rst.data", frame_data, 0);
        chk("rst.ovf", frame_ovf, 0);
        chk("rst.parity", frame_parity, 0);
        chk("rst.count", ovf_count, 0);
        chk("rst.drop", drop_err, 0);

        for (int k = 0; k < 18; k++) begin
            sample_en   = tv[k].se;
            bit_in      = tv[k].b;
            ovf_in      = tv[k].o;
            frame_ready = tv[k].r;
            tick();
            chk($sformatf("tbl%0d.valid", k), frame_valid, tv[k].v);
            chk($sformatf("tbl%0d.data", k), frame_data, tv[k].d);
            chk($sformatf("tbl%0d.ovf", k), frame_ovf, tv[k].fo);
            chk($sformatf("tbl%0d.drop", k), drop_err, tv[k].dr);
            chk($sformatf("tbl%0d.count", k), ovf_count, tv[k].cnt);
            if (tv[k].v) chk($sformatf("tbl%0d.parity", k), frame_parity, par_of(tv[k].d));
        end
        idle_inputs();

        // Buffer full: second frame is dropped, first one survives
        frame_ready = 1'b0;
        send(8'hFF, 8'h00);
        chk("drop.first_valid", frame_valid, 1);
        chk("drop.first_data", frame_data, 8'hFF);
        chk("drop.no_early_drop", drop_err, 0);
        send(8'h01, 8'h00);
        chk("drop.pulse", drop_err, 1);
        chk("drop.held_valid", frame_valid, 1);
        chk("drop.held_data", frame_data, 8'hFF);
        tick();
        chk("drop.pulse_end", drop_err, 0);
        chk("drop.still_data", frame_data, 8'hFF);
        frame_ready = 1'b1;
        tick();
        chk("drop.after_xfer_valid", frame_valid, 0);
        tick();
        chk("drop.stays_empty", frame_valid, 0);

        // Back-to-back: completion while the buffer drains
        frame_ready = 1'b0;
        send(8'hAA, 8'h00);
        chk("b2b.first_data", frame_data, 8'hAA);
        pat = 8'h55;
        for (int i = 7; i >= 0; i--) begin
            sample_en   = 1'b1;
            bit_in      = pat[i];
            frame_ready = (i == 0);
            tick();
        end
        idle_inputs();
        chk("b2b.valid", frame_valid, 1);
        chk("b2b.data", frame_data, 8'h55);
        chk("b2b.drop", drop_err, 0);
        chk("b2b.parity", frame_parity, par_of(8'h55));
        frame_ready = 1'b1;
        tick();
        chk("b2b.drain", frame_valid, 0);

        // Saturation with sample_en gaps that must be ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("sat.start", ovf_count, 0);
        sat_bits = 16'hC3A5;
        frame_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample_en = 1'b1;
            bit_in    = (i < 16) ? sat_bits[15-i] : 1'b0;
            ovf_in    = 1'b1;
            tick();
            chk($sformatf("sat%0d.count", i), ovf_count, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
            if (i == 7) begin
                chk("sat.frame1_valid", frame_valid, 1);
                chk("sat.frame1_data", frame_data, 8'hC3);
                chk("sat.frame1_ovf", frame_ovf, 1);
            end
            if (i == 15) begin
                chk("sat.frame2_valid", frame_valid, 1);
                chk("sat.frame2_data", frame_data, 8'hA5);
            end
            if (i == 3 || i == 10) begin
                sample_en = 1'b0;
                bit_in    = ~bit_in;
                ovf_in    = 1'b1;
                tick();
                tick();
                chk($sformatf("sat%0d.gap_count", i), ovf_count, i + 1);
            end
        end
        idle_inputs();

        // Reset mid-frame with a buffered frame pending; reset beats strobe
        frame_ready = 1'b0;
        send(8'h5A, 8'h00);
        chk("rmid.buffered", frame_valid, 1);
        for (int i = 0; i < 5; i++) begin
            sample_en = 1'b1;
            bit_in    = 1'b1;
            tick();
        end
        reset       = 1'b1;
        sample_en   = 1'b1;
        bit_in      = 1'b1;
        ovf_in      = 1'b1;
        frame_ready = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        chk("rmid.valid", frame_valid, 0);
        chk("rmid.data", frame_data, 0);
        chk("rmid.ovf", frame_ovf, 0);
        chk("rmid.parity", frame_parity, 0);
        chk("rmid.count", ovf_count, 0);
        chk("rmid.drop", drop_err, 0);
        send(8'h3C, 8'h00);
        chk("rmid.clean_valid", frame_valid, 1);
        chk("rmid.clean_data", frame_data, 8'h3C);
        chk("rmid.clean_ovf", frame_ovf, 0);
        chk("rmid.clean_parity", frame_parity, par_of(8'h3C));

        // Randomized phase against the reference model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 800; c++) begin
            logic rst_r;
            rst_r       = ($urandom_range(0, 299) == 0);
            reset       = rst_r;
            sample_en   = ($urandom_range(0, 99) < 60);
            bit_in      = 1'($urandom_range(0, 1));
            ovf_in      = ($urandom_range(0, 99) < 8);
            frame_ready = ($urandom_range(0, 99) < 45);
            model_step(rst_r, sample_en, bit_in, ovf_in, frame_ready);
            tick();
            chk($sformatf("rnd%0d.valid", c), frame_valid, m_valid);
            chk($sformatf("rnd%0d.drop", c), drop_err, m_drop);
            chk($sformatf("rnd%0d.count", c), ovf_count, m_cnt);
            if (m_valid) begin
                chk($sformatf("rnd%0d.data", c), frame_data, m_data);
                chk($sformatf("rnd%0d.ovf", c), frame_ovf, m_ovf);
                chk($sformatf("rnd%0d.parity", c), frame_parity, m_par);
            end
        end
        reset = 1'b0;
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/outp_frame_collector.md
Name: outp_frame_collector

Overview:
- Downstream consumer of the serial dual-line comparator FSM.
- Samples its 1-bit result stream (outp) and overflow flag (overflw) on a strobe, then packs FRAME_W samples into a parallel word.
- Presents each word through a single-entry valid/ready output buffer, with per-frame overflow status and a saturating overflow-event counter.
- Sits between the comparator FSM and the bus-side logger.

Parameters:
- FRAME_W, 8: bits per frame (legal range 2..32).
- OVF_CNT_W, 4: width of the saturating overflow-event counter.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high.
- sample_en, input, 1: strobe; bit_in and ovf_in are sampled only in cycles where it is 1.
- bit_in, input, 1: serial data, driven by the comparator outp.
- ovf_in, input, 1: overflow flag, driven by the comparator overflw.
- frame_ready, input, 1: consumer accepts the output word.
- frame_valid, output, 1: output buffer holds a complete frame.
- frame_data, output, FRAME_W: completed frame; first sampled bit is in the MSB.
- frame_ovf, output, 1: ovf_in was 1 on at least one sample of this frame.
- frame_parity, output, 1: XOR of frame_data bits (see Optional Feature).
- ovf_count, output, OVF_CNT_W: saturating count of samples with ovf_in=1.
- drop_err, output, 1: one-cycle pulse when a completed frame is discarded.

Behaviour:
- Reset (synchronous, active-high, on clock rising edge) clears all outputs to 0, the shift register, bit counter, sticky overflow bit and FSM (to IDLE). It aborts any partial frame and any buffered frame. Reset wins over all other inputs in the same cycle.
- FSM states: IDLE (bit counter 0, nothing collected) and SHIFT (1..FRAME_W-1 bits collected).
  - IDLE -> SHIFT on the first sample_en.
  - SHIFT -> IDLE on the sample_en that completes the frame.
  - sample_en=0 holds all collection state; there is no timeout.
- Shift register: on sample_en, sreg <= {sreg[FRAME_W-2:0], bit_in}. The bit counter increments modulo FRAME_W and wraps to 0 on completion.
- Sticky frame overflow: on sample_en, frame_ovf_acc <= frame_ovf_acc | ovf_in. It clears on completion, with the completing sample's ovf_in included in the completed frame.
- Completion happens on the sample_en cycle where the counter = FRAME_W-1. The assembled word is {sreg[FRAME_W-2:0], bit_in}.
  - If the buffer is empty, or frame_valid & frame_ready in that same cycle: load frame_data, frame_ovf and frame_parity, and set frame_valid=1 on the next edge.
  - Latency: frame_valid rises 1 cycle after the final sample.
  - Otherwise (buffer full and not draining): discard the new frame, pulse drop_err for 1 cycle, leave buffered contents unchanged. Collection restarts in IDLE either way.
- Output handshake:
  - Transfer occurs when frame_valid & frame_ready.
  - frame_valid clears the next cycle unless a completion reloads the buffer in the same cycle (back-to-back). In that case frame_valid stays 1 and the data is new.
  - frame_data, frame_ovf and frame_parity are stable while frame_valid=1 and not transferred. Their values are don't-care while frame_valid=0, but the RTL holds the last value.
- ovf_count:
  - Increments by 1 on each sample_en with ovf_in=1.
  - Saturates at 2^OVF_CNT_W-1.
  - Not affected by drops; cleared only by reset.
- ovf_in and bit_in are ignored when sample_en=0.

Optional Feature:
- Macro: OUTP_FRAME_COLLECTOR_PARITY_EN.
- Defined: frame_parity is registered alongside frame_data as the XOR-reduction of the completed word, computed incrementally with a running parity bit that resets per frame.
- Undefined: the parity logic is omitted and frame_parity is tied to 0. The port list is unchanged.

Test Plan:
- Reset, then FRAME_W=8, frame_ready=1, 8 consecutive sample_en with bit_in 1,0,1,1,0,0,1,0 and ovf_in=0 -> frame_data=8'hB2, frame_valid=1 for exactly 1 cycle starting 1 cycle after the 8th sample, frame_ovf=0, frame_parity=0 (macro on), ovf_count=0.
- Same frame with ovf_in=1 on the 3rd and 8th samples -> frame_ovf=1, ovf_count=2.
- frame_ready=0 with two full frames sent (8'hFF then 8'h01) -> first frame held (frame_data=8'hFF, frame_valid=1); drop_err pulses once at the 2nd completion; after frame_ready=1 one transfer of 8'hFF occurs and frame_valid then drops.
- Completion coinciding with frame_valid & frame_ready (buffer 8'hAA, new 8'h55) -> frame_valid stays 1, frame_data=8'h55 next cycle, no drop_err.
- OVF_CNT_W=4, 20 samples all with ovf_in=1 -> ovf_count saturates at 4'hF; gaps with sample_en=0 mid-frame do not advance the counter or alter the data.
- Reset asserted after 5 of 8 bits, with a buffered frame pending -> frame_valid=0 and all outputs 0 next cycle; the next 8 samples form a clean new frame.
